// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: bundles the pipeline-control request and response signals.
//   master : the pipeline side (drives hazard/EX/MEM/exception requests,
//            observes stall, flush, redirect, EX done, MEM timeout, counter)
//   slave  : the pipe_ctrl block itself
interface pipe_ctrl_if;
    logic        stallreq_id;   // ID-stage load-use stall request
    logic        ex_mc_start;   // pulse: multicycle EX op begins
    logic [3:0]  ex_mc_len;     // EX op length in cycles
    logic        mem_req;       // MEM stage has a pending bus access
    logic        mem_ack;       // bus completes the access this cycle
    logic        excp_valid;    // exception / flush request
    logic [31:0] excp_vector;   // handler address
    logic [5:0]  stall;         // per-stage hold, bit0 PC .. bit5 WB
    logic        flush;         // clear all pipeline registers
    logic [31:0] new_pc;        // redirect address while flush=1
    logic        ex_mc_done;    // EX multicycle result valid
    logic        mem_timeout;   // pulse: MEM access aborted
    logic [15:0] stall_cnt;     // cycles with stall[0]=1, saturating

    modport master (
        output stallreq_id, ex_mc_start, ex_mc_len, mem_req, mem_ack,
               excp_valid, excp_vector,
        input  stall, flush, new_pc, ex_mc_done, mem_timeout, stall_cnt
    );

    modport slave (
        input  stallreq_id, ex_mc_start, ex_mc_len, mem_req, mem_ack,
               excp_valid, excp_vector,
        output stall, flush, new_pc, ex_mc_done, mem_timeout, stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall/flush controller for a 6-stage pipeline.
//   clk  : clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : pipe_ctrl_if.slave -- hazard, multicycle-EX, MEM-wait and
//          exception inputs; stall vector, flush/redirect, EX done,
//          MEM timeout pulse and saturating stall-cycle counter outputs.
// MEM_TIMEOUT: number of MEM wait cycles tolerated before the access is
//              aborted with a one-cycle mem_timeout pulse.
module pipe_ctrl #(
    parameter logic [7:0] MEM_TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);
    typedef enum logic {IDLE, EX_BUSY} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [7:0]  wcnt;
    logic [15:0] stall_cnt_q;

    logic start_ok, ex_stall, mem_wait, mem_hit, mem_stall;

    always_comb begin
        start_ok  = (state == IDLE) && bus.ex_mc_start && (bus.ex_mc_len != 4'd0);
        ex_stall  = start_ok || ((state == EX_BUSY) && (cnt > 4'd1));
        mem_wait  = bus.mem_req && !bus.mem_ack;
        // Once the wait budget is spent the access is abandoned: the stage
        // is released in the same cycle the timeout pulse goes out.
        mem_hit   = mem_wait && (wcnt == MEM_TIMEOUT);
        mem_stall = mem_wait && !mem_hit;
    end

    // Reset and flush mask every output; flush also suppresses done/timeout.
    always_comb begin
        bus.stall       = 6'b000000;
        bus.flush       = 1'b0;
        bus.new_pc      = 32'h0;
        bus.ex_mc_done  = 1'b0;
        bus.mem_timeout = 1'b0;
        if (!rst) begin
            if (bus.excp_valid) begin
                bus.flush  = 1'b1;
                bus.new_pc = bus.excp_vector;
            end else begin
                bus.ex_mc_done  = ((state == EX_BUSY) && (cnt == 4'd1)) ||
                                  ((state == IDLE) && bus.ex_mc_start &&
                                   (bus.ex_mc_len == 4'd0));
                bus.mem_timeout = mem_hit;
                if (mem_stall)            bus.stall = 6'b011111;
                else if (ex_stall)        bus.stall = 6'b001111;
                else if (bus.stallreq_id) bus.stall = 6'b000111;
            end
        end
    end

    assign bus.stall_cnt = stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            wcnt        <= 8'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            if (bus.stall[0] && (stall_cnt_q != 16'hFFFF))
                stall_cnt_q <= stall_cnt_q + 16'd1;

            if (bus.excp_valid) begin
                // Flush discards any in-flight EX op and MEM wait, including
                // a start arriving in the same cycle.
                state <= IDLE;
                cnt   <= 4'd0;
                wcnt  <= 8'd0;
            end else begin
                if (mem_wait && !mem_hit) wcnt <= wcnt + 8'd1;
                else                      wcnt <= 8'd0;

                case (state)
                    IDLE: begin
                        if (start_ok) begin
                            state <= EX_BUSY;
                            cnt   <= bus.ex_mc_len;
                        end
                    end
                    EX_BUSY: begin
                        // Counts down regardless of MEM stalls; starts ignored.
                        cnt <= cnt - 4'd1;
                        if (cnt <= 4'd1) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    pipe_ctrl_if bus ();

    pipe_ctrl #(.MEM_TIMEOUT(8'd4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic cyc;
        @(negedge clk);
    endtask

    task automatic idle_in;
        bus.stallreq_id = 1'b0;
        bus.ex_mc_start = 1'b0;
        bus.ex_mc_len   = 4'd0;
        bus.mem_req     = 1'b0;
        bus.mem_ack     = 1'b0;
        bus.excp_valid  = 1'b0;
        bus.excp_vector = 32'h0;
    endtask

    initial begin
        rst = 1'b1;
        idle_in();
        cyc(); cyc();
        // Reset masks all outputs even with every request asserted.
        bus.stallreq_id = 1'b1; bus.ex_mc_start = 1'b1; bus.ex_mc_len = 4'd0;
        bus.mem_req = 1'b1; bus.excp_valid = 1'b1; bus.excp_vector = 32'hDEAD_BEEF;
        #1;
        chk("rst_stall", {26'd0, bus.stall}, 32'h0);
        chk("rst_flush", {31'd0, bus.flush}, 32'h0);
        chk("rst_new_pc", bus.new_pc, 32'h0);
        chk("rst_done", {31'd0, bus.ex_mc_done}, 32'h0);
        chk("rst_timeout", {31'd0, bus.mem_timeout}, 32'h0);
        cyc(); #1;
        chk("rst_stall_cnt", {16'd0, bus.stall_cnt}, 32'h0);

        // Multicycle EX, len=3: three stall cycles then done.
        cyc(); rst = 1'b0; idle_in();
        bus.ex_mc_start = 1'b1; bus.ex_mc_len = 4'd3; #1;
        chk("ex3_t0_stall", {26'd0, bus.stall}, 32'h0F);
        chk("ex3_t0_done", {31'd0, bus.ex_mc_done}, 32'h0);
        cyc(); idle_in(); bus.ex_mc_start = 1'b1; bus.ex_mc_len = 4'd7; #1;
        chk("ex3_t1_stall_ign_start", {26'd0, bus.stall}, 32'h0F);
        cyc(); idle_in(); #1;
        chk("ex3_t2_stall", {26'd0, bus.stall}, 32'h0F);
        cyc(); #1;
        chk("ex3_t3_stall", {26'd0, bus.stall}, 32'h0);
        chk("ex3_t3_done", {31'd0, bus.ex_mc_done}, 32'h1);
        chk("ex3_stall_cnt", {16'd0, bus.stall_cnt}, 32'd3);
        cyc(); #1;
        chk("ex3_after_done", {31'd0, bus.ex_mc_done}, 32'h0);

        // MEM wait overlapping EX_BUSY (len=5): MEM dominates, EX keeps counting.
        cyc(); bus.ex_mc_start = 1'b1; bus.ex_mc_len = 4'd5; #1;
        chk("exmem_start", {26'd0, bus.stall}, 32'h0F);
        cyc(); idle_in(); bus.mem_req = 1'b1; #1;
        chk("exmem_m0", {26'd0, bus.stall}, 32'h1F);
        cyc(); #1;
        chk("exmem_m1", {26'd0, bus.stall}, 32'h1F);
        cyc(); #1;
        chk("exmem_m2", {26'd0, bus.stall}, 32'h1F);
        cyc(); #1;
        chk("exmem_m3", {26'd0, bus.stall}, 32'h1F);
        chk("exmem_m3_done", {31'd0, bus.ex_mc_done}, 32'h0);
        cyc(); bus.mem_ack = 1'b1; #1;
        chk("exmem_ack_stall", {26'd0, bus.stall}, 32'h0);
        chk("exmem_ack_done", {31'd0, bus.ex_mc_done}, 32'h1);
        chk("exmem_stall_cnt", {16'd0, bus.stall_cnt}, 32'd8);

        // MEM timeout with MEM_TIMEOUT=4.
        cyc(); idle_in(); bus.mem_req = 1'b1; #1;
        chk("to_w0", {26'd0, bus.stall}, 32'h1F);
        cyc(); #1; chk("to_w1", {26'd0, bus.stall}, 32'h1F);
        cyc(); #1; chk("to_w2", {26'd0, bus.stall}, 32'h1F);
        cyc(); #1;
        chk("to_w3", {26'd0, bus.stall}, 32'h1F);
        chk("to_w3_pulse", {31'd0, bus.mem_timeout}, 32'h0);
        cyc(); #1;
        chk("to_hit_stall", {26'd0, bus.stall}, 32'h0);
        chk("to_hit_pulse", {31'd0, bus.mem_timeout}, 32'h1);
        cyc(); #1;
        chk("to_restart_stall", {26'd0, bus.stall}, 32'h1F);
        chk("to_restart_pulse", {31'd0, bus.mem_timeout}, 32'h0);
        cyc(); idle_in(); #1;
        chk("to_stall_cnt", {16'd0, bus.stall_cnt}, 32'd13);

        // Exception during EX_BUSY with cnt=5.
        cyc(); bus.ex_mc_start = 1'b1; bus.ex_mc_len = 4'd5;
        cyc(); idle_in(); bus.excp_valid = 1'b1; bus.excp_vector = 32'h0000_0020; #1;
        chk("fl_flush", {31'd0, bus.flush}, 32'h1);
        chk("fl_new_pc", bus.new_pc, 32'h20);
        chk("fl_stall", {26'd0, bus.stall}, 32'h0);
        chk("fl_done", {31'd0, bus.ex_mc_done}, 32'h0);
        cyc(); idle_in(); #1;
        chk("fl_next_stall", {26'd0, bus.stall}, 32'h0);
        chk("fl_next_new_pc", bus.new_pc, 32'h0);
        cyc(); #1;
        chk("fl_next2_done", {31'd0, bus.ex_mc_done}, 32'h0);

        // Flush beats a simultaneous start; the start is discarded.
        cyc(); bus.excp_valid = 1'b1; bus.excp_vector = 32'h100;
        bus.ex_mc_start = 1'b1; bus.ex_mc_len = 4'd3; #1;
        chk("flst_stall", {26'd0, bus.stall}, 32'h0);
        cyc(); idle_in(); #1;
        chk("flst_next_stall", {26'd0, bus.stall}, 32'h0);

        // Flush mid MEM wait clears wcnt: full 4-cycle budget afterwards.
        cyc(); bus.mem_req = 1'b1;
        cyc(); cyc(); cyc();
        bus.excp_valid = 1'b1; #1;
        chk("flmem_stall", {26'd0, bus.stall}, 32'h0);
        chk("flmem_pulse", {31'd0, bus.mem_timeout}, 32'h0);
        cyc(); bus.excp_valid = 1'b0; #1;
        chk("flmem_w0", {26'd0, bus.stall}, 32'h1F);
        cyc(); cyc(); cyc(); #1;
        chk("flmem_w3", {26'd0, bus.stall}, 32'h1F);
        cyc(); #1;
        chk("flmem_hit", {31'd0, bus.mem_timeout}, 32'h1);

        // stallreq_id with zero-length EX op in the same cycle.
        cyc(); idle_in(); bus.stallreq_id = 1'b1; bus.ex_mc_start = 1'b1; bus.ex_mc_len = 4'd0; #1;
        chk("id_len0_stall", {26'd0, bus.stall}, 32'h07);
        chk("id_len0_done", {31'd0, bus.ex_mc_done}, 32'h1);
        cyc(); idle_in(); #1;
        chk("id_len0_after", {26'd0, bus.stall}, 32'h0);
        chk("id_len0_cnt", {16'd0, bus.stall_cnt}, 32'd22);

        // Reset mid-op aborts EX with no done.
        cyc(); bus.ex_mc_start = 1'b1; bus.ex_mc_len = 4'd5;
        cyc(); idle_in(); rst = 1'b1; #1;
        chk("rstmid_stall", {26'd0, bus.stall}, 32'h0);
        cyc(); rst = 1'b0; #1;
        chk("rstmid_after_stall", {26'd0, bus.stall}, 32'h0);
        chk("rstmid_after_done", {31'd0, bus.ex_mc_done}, 32'h0);
        chk("rstmid_stall_cnt", {16'd0, bus.stall_cnt}, 32'h0);

        // Saturation of stall_cnt under continuous ID stall.
        bus.stallreq_id = 1'b1;
        for (int i = 0; i < 65534; i++) cyc();
        #1;
        chk("sat_fffe", {16'd0, bus.stall_cnt}, 32'h0000_FFFE);
        cyc(); #1;
        chk("sat_ffff", {16'd0, bus.stall_cnt}, 32'h0000_FFFF);
        cyc(); cyc(); cyc(); #1;
        chk("sat_hold", {16'd0, bus.stall_cnt}, 32'h0000_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
